mul_issue_ctrl: RTL and testbench

//  Sequencer and two-port arbiter for the iterative radix-4 Booth multiplier (17 enabled cycles per op).

---
 rtl/mul_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_mul_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Two-port round-robin issue sequencer for the iterative radix-4 Booth multiplier.
// One op in flight: grant, run the unit for MUL_CYCLES+1 enabled cycles, capture, respond.
module mul_issue_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned MUL_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*XLEN-1:0]    req_a_i,
  input  logic [2*XLEN-1:0]    req_b_i,
  input  logic [3:0]           req_op_i,
  input  logic [2*TAG_W-1:0]   req_tag_i,
  input  logic                 flush_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [XLEN-1:0]      rsp_data_o,
  output logic [TAG_W-1:0]     rsp_tag_o,
  output logic                 rsp_port_o,
  output logic [XLEN-1:0]      mul_a_o,
  output logic [XLEN-1:0]      mul_b_o,
  output logic [1:0]           mul_op_o,
  output logic                 mul_clk_en_o,
  input  logic                 mul_free_i,
  input  logic [XLEN-1:0]      mul_result_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, CAPT, RESP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             killed_q;

  logic             gnt_valid;
  logic             gnt_port;
  logic [XLEN-1:0]  sel_a;
  logic [XLEN-1:0]  sel_b;
  logic [1:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;

  // Grant is combinational so the requester sees ready in the same cycle;
  // suppressed during reset because the state cannot advance then.
  always_comb begin
    gnt_valid = (state_q == IDLE) && (|req_valid_i) && !flush_i && !rst_i;
    if (req_valid_i == 2'b11) gnt_port = ~last_q;
    else                      gnt_port = req_valid_i[1];
    req_ready_o = '0;
    if (gnt_valid) req_ready_o = gnt_port ? 2'b10 : 2'b01;
    sel_a   = gnt_port ? req_a_i[2*XLEN-1:XLEN]    : req_a_i[XLEN-1:0];
    sel_b   = gnt_port ? req_b_i[2*XLEN-1:XLEN]    : req_b_i[XLEN-1:0];
    sel_op  = gnt_port ? req_op_i[3:2]             : req_op_i[1:0];
    sel_tag = gnt_port ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      killed_q     <= 1'b0;
      mul_a_o      <= '0;
      mul_b_o      <= '0;
      mul_op_o     <= '0;
      mul_clk_en_o <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_tag_o    <= '0;
      rsp_port_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            mul_a_o      <= sel_a;
            mul_b_o      <= sel_b;
            mul_op_o     <= sel_op;
            rsp_tag_o    <= sel_tag;
            rsp_port_o   <= gnt_port;
            last_q       <= gnt_port;
            cnt_q        <= '0;
            killed_q     <= 1'b0;
            mul_clk_en_o <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          // The unit cannot abort, so a flush only marks the op; it still runs to completion.
          if (flush_i) killed_q <= 1'b1;
          if (cnt_q == CNT_MAX) begin
            mul_clk_en_o <= 1'b0;
            state_q      <= CAPT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CAPT: begin
          if (!mul_free_i) err_o <= 1'b1;
          if (killed_q || flush_i) begin
            mul_a_o  <= '0;
            mul_b_o  <= '0;
            mul_op_o <= '0;
            state_q  <= IDLE;
          end else begin
            rsp_data_o  <= mul_result_i;
            rsp_valid_o <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i || flush_i) begin
            rsp_valid_o <= 1'b0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            mul_op_o    <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a cycle-counting model of the Booth unit.
module tb_mul_issue_ctrl;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned MUL_CYCLES = 16;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [2*XLEN-1:0]  req_a_i, req_b_i;
  logic [3:0]         req_op_i;
  logic [2*TAG_W-1:0] req_tag_i;
  logic               flush_i;
  logic               rsp_valid_o, rsp_ready_i;
  logic [XLEN-1:0]    rsp_data_o;
  logic [TAG_W-1:0]   rsp_tag_o;
  logic               rsp_port_o;
  logic [XLEN-1:0]    mul_a_o, mul_b_o;
  logic [1:0]         mul_op_o;
  logic               mul_clk_en_o, mul_free_i;
  logic [XLEN-1:0]    mul_result_i;
  logic               busy_o, err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mul_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i), .req_tag_i(req_tag_i),
    .flush_i(flush_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o), .rsp_port_o(rsp_port_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_op_o(mul_op_o), .mul_clk_en_o(mul_clk_en_o),
    .mul_free_i(mul_free_i), .mul_result_i(mul_result_i), .busy_o(busy_o), .err_o(err_o)
  );

  // Unit model: free when its iteration counter is 0; result computed from live operands.
  logic [4:0]  ucnt;
  logic        force_busy;
  logic [63:0] sa, sb, ua, ub, prod;

  always @(posedge clk_i) begin
    if (rst_i) ucnt <= '0;
    else if (mul_clk_en_o) ucnt <= (ucnt == 5'd16) ? 5'd0 : ucnt + 5'd1;
  end
  assign mul_free_i = (ucnt == 5'd0) && !force_busy;

  always_comb begin
    sa = {{32{mul_a_o[31]}}, mul_a_o};
    sb = {{32{mul_b_o[31]}}, mul_b_o};
    ua = {32'b0, mul_a_o};
    ub = {32'b0, mul_b_o};
    prod = '0;
    case (mul_op_o)
      2'd0, 2'd1: prod = sa * sb;
      2'd2:       prod = sa * ub;
      default:    prod = ua * ub;
    endcase
    mul_result_i = (mul_op_o == 2'd0) ? prod[31:0] : prod[63:32];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; presents a single-port request and checks it is granted this cycle.
  task automatic issue(input logic p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    req_valid_i = p ? 2'b10 : 2'b01;
    req_a_i[p*32 +: 32] = a;
    req_b_i[p*32 +: 32] = b;
    req_op_i[p*2 +: 2] = op;
    req_tag_i[p*4 +: 4] = tag;
    #3;
    chk("grant_ready", req_ready_o, p ? 2'b10 : 2'b01);
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
  endtask

  // Counts enabled cycles and posedges from the grant edge until rsp_valid_o (lat=0 on timeout).
  task automatic wait_rsp(output int lat, output int en_cnt);
    en_cnt = mul_clk_en_o ? 1 : 0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_i); #1;
      if (mul_clk_en_o) en_cnt++;
      if (rsp_valid_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    chk("hs_idle", {rsp_valid_o, busy_o}, 2'b00);
  endtask

  typedef struct {
    logic        port;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en_cnt, dual, gcount, busy18, seen_v;
    logic grants[4];

    // op encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
    vecs[0] = '{1'b0, 2'd0, 32'd7,        32'hFFFFFFFD, 4'd5,  32'hFFFFFFEB};
    vecs[1] = '{1'b1, 2'd1, 32'h80000000, 32'd2,        4'd3,  32'hFFFFFFFF};
    vecs[2] = '{1'b0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9,  32'hFFFFFFFE};
    vecs[3] = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hA,  32'hFFFFFFFF};
    vecs[4] = '{1'b0, 2'd0, 32'h00010000, 32'h00010000, 4'hF,  32'h00000000};
    vecs[5] = '{1'b1, 2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'd1,  32'h3FFFFFFF};
    vecs[6] = '{1'b0, 2'd2, 32'd2,        32'h80000000, 4'd2,  32'h00000001};

    rst_i = 1'b1; req_valid_i = 2'b01; req_a_i = '0; req_b_i = '0; req_op_i = '0;
    req_tag_i = '0; flush_i = 1'b0; rsp_ready_i = 1'b0; force_busy = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_flags", {busy_o, rsp_valid_o, mul_clk_en_o, err_o}, 4'b0000);
    chk("rst_ops", {mul_a_o, mul_b_o}, 64'h0);
    chk("rst_rsp", {mul_op_o, rsp_data_o, rsp_tag_o, rsp_port_o}, 39'h0);
    req_valid_i = 2'b00;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Round-robin with both ports requesting continuously.
    req_a_i = {32'd4, 32'd3}; req_b_i = {32'd5, 32'd6};
    rsp_ready_i = 1'b1; req_valid_i = 2'b11;
    dual = 0; gcount = 0;
    for (int c = 0; c < 120 && gcount < 4; c++) begin
      @(negedge clk_i);
      if (req_ready_o == 2'b11) dual++;
      if (req_ready_o != 2'b00) begin
        grants[gcount] = req_ready_o[1];
        gcount++;
      end
    end
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    chk("rr_count", gcount, 4);
    chk("rr_onehot", dual, 0);
    for (int i = 0; i < 4 && i < gcount; i++) chk($sformatf("rr_grant%0d", i), grants[i], i % 2);
    for (int c = 0; c < 40 && busy_o; c++) begin
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 1'b0;
    chk("rr_drain", busy_o, 1'b0);

    // Table-driven single operations.
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_rsp(lat, en_cnt);
      chk($sformatf("v%0d_latency", i), lat, 18);
      chk($sformatf("v%0d_clk_en", i), en_cnt, 17);
      chk($sformatf("v%0d_data", i), rsp_data_o, vecs[i].exp);
      chk($sformatf("v%0d_tag_port", i), {rsp_tag_o, rsp_port_o}, {vecs[i].tag, vecs[i].port});
      handshake();
    end

    // Back-pressured response holds and blocks new grants.
    issue(1'b1, 2'd1, 32'h80000000, 32'd2, 4'd6);
    wait_rsp(lat, en_cnt);
    chk("bp_latency", lat, 18);
    req_valid_i = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk($sformatf("bp_hold%0d", k), {req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o},
          {2'b00, 1'b1, 32'hFFFFFFFF, 4'd6});
      @(posedge clk_i); #1;
    end
    req_valid_i = 2'b00;
    handshake();

    // Flush at RUN cnt=5: unit keeps running, no response.
    issue(1'b0, 2'd0, 32'd3, 32'd4, 4'd7);
    en_cnt = mul_clk_en_o ? 1 : 0;
    seen_v = 0; busy18 = 1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk_i); #1;
      if (n == 5) flush_i = 1'b1;
      if (n == 6) flush_i = 1'b0;
      if (mul_clk_en_o) en_cnt++;
      if (rsp_valid_o) seen_v++;
      if (n == 18) busy18 = busy_o;
    end
    chk("flush_clk_en", en_cnt, 17);
    chk("flush_no_rsp", seen_v, 0);
    chk("flush_idle", busy18, 0);
    issue(1'b1, 2'd0, 32'd5, 32'd6, 4'd8);
    wait_rsp(lat, en_cnt);
    chk("post_flush", {lat[7:0], rsp_data_o, rsp_tag_o}, {8'd18, 32'd30, 4'd8});
    handshake();

    // Reset at RUN cnt=8, last grant was port 0.
    issue(1'b0, 2'd0, 32'd9, 32'd9, 4'd4);
    repeat (8) @(posedge clk_i);
    #1;
    rst_i = 1'b1; req_valid_i = 2'b11;
    @(posedge clk_i); #1;
    chk("midrst_flags", {busy_o, rsp_valid_o, mul_clk_en_o, err_o, req_ready_o}, 6'b0);
    chk("midrst_ops", {mul_a_o, mul_b_o, mul_op_o}, 66'h0);
    rst_i = 1'b0;
    #3;
    chk("midrst_rr", req_ready_o, 2'b01);
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    wait_rsp(lat, en_cnt);
    chk("midrst_op", {lat[7:0], rsp_data_o, rsp_port_o}, {8'd18, 32'd81, 1'b0});
    handshake();

    // Unit not free in CAPT -> sticky error.
    issue(1'b1, 2'd3, 32'hFFFFFFFF, 32'd2, 4'hC);
    repeat (17) @(posedge clk_i);
    #1;
    chk("err_pre", {busy_o, mul_clk_en_o, err_o}, 3'b100);
    force_busy = 1'b1;
    @(posedge clk_i); #1;
    force_busy = 1'b0;
    chk("err_set", {err_o, rsp_valid_o, rsp_data_o}, {1'b1, 1'b1, 32'd1});
    handshake();
    issue(1'b0, 2'd0, 32'd2, 32'd3, 4'd1);
    wait_rsp(lat, en_cnt);
    chk("err_sticky", {err_o, rsp_data_o}, {1'b1, 32'd6});
    handshake();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("err_clear", err_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
